// File: rtl/sync_fifo_ft_pkg.sv
// Shared definitions for the single-clock FIFO family: default sizes,
// read-mode constants and the depth helper used by the FIFO and its memory.
package sync_fifo_ft_pkg;

    localparam int SFIFO_DSIZE_DEF = 8;
    localparam int SFIFO_ASIZE_DEF = 2;

    // Read-mode selection for the FWFT parameter
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // What the fill counter does on a given edge
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Number of entries addressed by an ASIZE-bit address
    function automatic int depth_f(input int asize);
        return 32'sd1 <<< asize;
    endfunction

endpackage

// File: rtl/sfifo_mem.sv
// DEPTH x DSIZE register array: synchronous write, asynchronous read.
// Shared with the dual-clock FIFO; contents are deliberately not reset.
module sfifo_mem
    import sync_fifo_ft_pkg::*;
#(
    parameter int DSIZE = SFIFO_DSIZE_DEF,
    parameter int ASIZE = SFIFO_ASIZE_DEF
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int DEPTH = depth_f(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];

    // Store the incoming word when the write port is enabled
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sync_fifo_ft.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable first-word-fall-through.
// All status outputs are registered, computed from the next-state count so
// they never depend combinationally on i_wr / i_rd.
module sync_fifo_ft
    import sync_fifo_ft_pkg::*;
#(
    parameter int DSIZE     = SFIFO_DSIZE_DEF,
    parameter int ASIZE     = SFIFO_ASIZE_DEF,
    parameter int FWFT      = FWFT_OFF,
    parameter int AF_THRESH = depth_f(ASIZE) - 1,
    parameter int AE_THRESH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [DSIZE-1:0] i_wdata,
    output logic             o_wfull,
    output logic             o_almost_full,
    input  logic             i_rd,
    output logic [DSIZE-1:0] o_rdata,
    output logic             o_rempty,
    output logic             o_almost_empty,
    output logic [ASIZE:0]   o_count,
    output logic             o_overflow,
    output logic             o_underflow,
    input  logic             i_clr_err
);

    localparam int DEPTH = depth_f(ASIZE);

    localparam logic [ASIZE:0] DEPTH_L  = DEPTH[ASIZE:0];
    localparam logic [ASIZE:0] AF_TH_L  = AF_THRESH[ASIZE:0];
    localparam logic [ASIZE:0] AE_TH_L  = AE_THRESH[ASIZE:0];
    localparam logic [ASIZE:0] ONE_L    = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] ZERO_L   = {(ASIZE+1){1'b0}};

    // Reject illegal configurations at elaboration time
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $fatal(1, "sync_fifo_ft: AF_THRESH must be within 1..DEPTH");
    end else begin : g_ok_af
    end

    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $fatal(1, "sync_fifo_ft: AE_THRESH must be within 0..DEPTH-1");
    end else begin : g_ok_ae
    end

    if ((FWFT != FWFT_OFF) && (FWFT != FWFT_ON)) begin : g_bad_fwft
        $fatal(1, "sync_fifo_ft: FWFT must be FWFT_OFF or FWFT_ON");
    end else begin : g_ok_fwft
    end

    // State registers and their next-state values
    logic [ASIZE:0]   wptr_q,  wptr_d;
    logic [ASIZE:0]   rptr_q,  rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q,   ovf_d;
    logic             udf_q,   udf_d;

    logic             wr_ok_s;
    logic             rd_ok_s;
    cnt_op_e          cnt_op_s;
    logic [DSIZE-1:0] mem_rdata_s;

    sfifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_ok_s),
        .i_waddr (wptr_q[ASIZE-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (rptr_q[ASIZE-1:0]),
        .o_rdata (mem_rdata_s)
    );

    // Accept decisions use only the registered full/empty state
    always_comb begin
        wr_ok_s = i_wr & ~wfull_q;
        rd_ok_s = i_rd & ~rempty_q;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_op_s = CNT_INC;
            2'b01:   cnt_op_s = CNT_DEC;
            default: cnt_op_s = CNT_HOLD;
        endcase
    end

    // Next pointers, count and read-data holding register
    always_comb begin
        if (wr_ok_s) begin
            wptr_d = wptr_q + ONE_L;
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_ok_s) begin
            rptr_d  = rptr_q + ONE_L;
            rdata_d = mem_rdata_s;
        end else begin
            rptr_d  = rptr_q;
            rdata_d = rdata_q;
        end

        case (cnt_op_s)
            CNT_INC: count_d = count_q + ONE_L;
            CNT_DEC: count_d = count_q - ONE_L;
            default: count_d = count_q;
        endcase
    end

    // Status flags for the coming cycle, decoded from the next count
    always_comb begin
        wfull_d  = (count_d == DEPTH_L);
        rempty_d = (count_d == ZERO_L);
        afull_d  = (count_d >= AF_TH_L);
        aempty_d = (count_d <= AE_TH_L);
    end

    // Sticky error flags: a new error on the clearing edge takes priority
    always_comb begin
        if (i_wr && wfull_q) begin
            ovf_d = 1'b1;
        end else if (i_clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (i_rd && rempty_q) begin
            udf_d = 1'b1;
        end else if (i_clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Register all FIFO control state; async reset empties the FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q   <= ZERO_L;
            rptr_q   <= ZERO_L;
            count_q  <= ZERO_L;
            rdata_q  <= {DSIZE{1'b0}};
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // In FWFT mode the head word is shown while data is present; otherwise
    // (and whenever empty) the last popped word is held
    always_comb begin
        if ((FWFT == FWFT_ON) && !rempty_q) begin
            o_rdata = mem_rdata_s;
        end else begin
            o_rdata = rdata_q;
        end
    end

    assign o_wfull        = wfull_q;
    assign o_almost_full  = afull_q;
    assign o_rempty       = rempty_q;
    assign o_almost_empty = aempty_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule
